// File: rtl/if_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_pkg
// Shared types and constants for the instruction-fetch sequencer.
//   RESET_PC_DEF / IM_WORDS_DEF : default text-window base and IM size
//   fetch_entry_t               : {pc, instr, fault} prefetch entry
//   fetch_state_e               : fetch sequencer state (fetching / halted)
//   addr_in_range()             : text-window + alignment check
// ---------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  // Window is [base, base + 4*words); the offset compare is done on the
  // 32-bit unsigned difference so the upper bound never overflows.
  function automatic logic addr_in_range(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input int unsigned words);
    logic [31:0] off;
    logic [31:0] span;
    off  = pc - base;
    span = 32'(words) << 2;
    return (pc >= base) && (off < span) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl_if
// Bundles the IM read port, redirect input and decode handshake.
//   master : fetch controller side (drives im_addr and the if_* outputs)
//   slave  : environment side (IM, branch unit, decode)
// With IF_FETCH_PERF_EN defined, perf_fetched / perf_stall are added.
// ---------------------------------------------------------------------------
interface if_fetch_ctrl_if;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  modport master (
    output im_addr,
    input  im_data,
    input  redirect,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_instr,
    output if_pc,
`ifdef IF_FETCH_PERF_EN
    output perf_fetched,
    output perf_stall,
`endif
    output if_fault
  );

  modport slave (
    input  im_addr,
    output im_data,
    output redirect,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_instr,
    input  if_pc,
`ifdef IF_FETCH_PERF_EN
    input  perf_fetched,
    input  perf_stall,
`endif
    input  if_fault
  );
endinterface

// File: rtl/if_fetch_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_buf
// 2-entry circular prefetch FIFO (1-bit rd/wr pointers, 2-bit count).
//   clk, reset : clock, synchronous active-high reset
//   flush_i    : empties the FIFO; overrides push/pop
//   push_i     : write wdata_i at the tail (caller guarantees space)
//   pop_i      : drop the head entry (caller guarantees non-empty)
//   head_o     : head entry, all-zero while empty
//   count_o    : number of valid entries (0..2)
// ---------------------------------------------------------------------------
module if_fetch_buf
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [DEPTH];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      // Stale data may remain in mem_q; head_o is masked by the count.
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= ~wr_q;
      end
      if (pop_i) rd_q <= ~rd_q;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Mux of registers only: no path from the IM into the head.
  assign head_o  = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// Instruction-fetch sequencer: owns the PC, reads one IM word per cycle
// into a 2-entry prefetch buffer and presents {pc, instr, fault} to decode
// over a valid/ready handshake. Redirects flush the buffer and restart
// fetch; out-of-window or misaligned PCs produce one fault entry and halt
// fetch until the next redirect.
//   clk, reset     : clock, synchronous active-high reset
//   bus (master)   : im_addr/im_data IM port, redirect/redirect_pc,
//                    id_ready, if_valid/if_instr/if_pc/if_fault
// Optional: define IF_FETCH_PERF_EN to add perf_fetched / perf_stall
// saturating counters on the interface.
// ---------------------------------------------------------------------------
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned IM_WORDS  = IM_WORDS_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  if_fetch_ctrl_if.master    bus
);

  logic [31:0]  pc_q;
  fetch_state_e state_q;

  fetch_entry_t head, wentry;
  logic [1:0]   count;
  logic         valid, in_range, pop, push;

  assign valid    = (count != 2'd0);
  assign in_range = addr_in_range(pc_q, RESET_PC, IM_WORDS);
  assign pop      = valid && bus.id_ready && !bus.redirect;
  // A full buffer only takes a push alongside a pop (the freed slot).
  assign push     = !bus.redirect && (state_q == ST_FETCH) &&
                    (!count[1] || pop);

  assign wentry.pc    = pc_q;
  assign wentry.instr = in_range ? bus.im_data : 32'h0;
  assign wentry.fault = !in_range;

  // PC / halt sequencer. A fault entry holds the PC and parks in ST_HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= ST_FETCH;
    end else if (bus.redirect) begin
      pc_q    <= bus.redirect_pc;
      state_q <= ST_FETCH;
    end else if (push) begin
      if (in_range) pc_q    <= pc_q + 32'd4;
      else          state_q <= ST_HALT;
    end
  end

  if_fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.im_addr  = pc_q;
  assign bus.if_valid = valid;
  assign bus.if_pc    = head.pc;
  assign bus.if_instr = head.instr;
  assign bus.if_fault = head.fault;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stall_q;
  logic        stall;

  // Raw handshake pop (not masked by redirect) decides whether a full
  // buffer counts as stalled.
  assign stall = count[1] && !(valid && bus.id_ready) && (state_q == ST_FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (push && in_range && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  if_fetch_ctrl_if bus ();

  if_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // IM model: word i at 0x3000 + 4*i holds 0x1000_0000 + i; garbage outside.
  logic [31:0] imem [4096];
  logic [31:0] im_off;
  assign im_off      = bus.im_addr - 32'h3000;
  assign bus.im_data = (im_off < 32'h4000) ? imem[im_off[13:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; outputs are sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 32'h1000_0000 + i;
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready    = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_pc",    bus.if_pc, 32'h0);
    chk("rst_fault", {31'b0, bus.if_fault}, 32'd0);
    chk("rst_imaddr", bus.im_addr, 32'h3000);

    // Streaming: one entry per cycle, 1-cycle latency
    reset = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", {31'b0, bus.if_valid}, 32'd1);
      chk("stream_pc",    bus.if_pc, 32'h3000 + 4 * i);
      chk("stream_instr", bus.if_instr, 32'h1000_0000 + i);
      tick();
    end

    // Backpressure: id_ready low for 5 cycles after reset
    bus.id_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("stall_pc",     bus.if_pc, 32'h3000);
    chk("stall_imaddr", bus.im_addr, 32'h3008);
`ifdef IF_FETCH_PERF_EN
    chk("perf_stall",   bus.perf_stall, 32'd3);
    chk("perf_fetched", bus.perf_fetched, 32'd2);
`endif
    bus.id_ready = 1'b1;
    tick();
    chk("resume_pc1", bus.if_pc, 32'h3004);
    tick();
    chk("resume_pc2", bus.if_pc, 32'h3008);
    chk("resume_in2", bus.if_instr, 32'h1000_0002);
    tick();
    chk("resume_pc3", bus.if_pc, 32'h300C);
`ifdef IF_FETCH_PERF_EN
    chk("perf_stall_hold", bus.perf_stall, 32'd3);
`endif

    // Redirect on a full buffer with a simultaneous pop
    bus.id_ready = 1'b0;
    do_reset();
    tick();
    tick();
    chk("full_pc", bus.if_pc, 32'h3000);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3100;
    bus.id_ready = 1'b1;
    tick();
    bus.redirect = 1'b0;
    chk("redir_valid0", {31'b0, bus.if_valid}, 32'd0);
    chk("redir_imaddr", bus.im_addr, 32'h3100);
    tick();
    chk("redir_valid1", {31'b0, bus.if_valid}, 32'd1);
    chk("redir_pc",     bus.if_pc, 32'h3100);
    chk("redir_instr",  bus.if_instr, 32'h1000_0040);

    // Misaligned redirect -> single fault entry, then halted
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3002;
    tick();
    bus.redirect = 1'b0;
    chk("mis_imaddr0", bus.im_addr, 32'h3002);
    tick();
    chk("mis_valid",  {31'b0, bus.if_valid}, 32'd1);
    chk("mis_fault",  {31'b0, bus.if_fault}, 32'd1);
    chk("mis_instr",  bus.if_instr, 32'h0);
    chk("mis_pc",     bus.if_pc, 32'h3002);
    tick();
    chk("halt_valid0", {31'b0, bus.if_valid}, 32'd0);
    tick();
    chk("halt_valid1", {31'b0, bus.if_valid}, 32'd0);
    chk("halt_imaddr", bus.im_addr, 32'h3002);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3000;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("unhalt_pc",    bus.if_pc, 32'h3000);
    chk("unhalt_fault", {31'b0, bus.if_fault}, 32'd0);

    // Top of the text window
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h6FF8;
    tick();
    bus.redirect = 1'b0;
    tick();
    chk("top_pc0",    bus.if_pc, 32'h6FF8);
    chk("top_in0",    bus.if_instr, 32'h1000_0FFE);
    tick();
    chk("top_pc1",    bus.if_pc, 32'h6FFC);
    chk("top_in1",    bus.if_instr, 32'h1000_0FFF);
    chk("top_f1",     {31'b0, bus.if_fault}, 32'd0);
    tick();
    chk("oob_pc",     bus.if_pc, 32'h7000);
    chk("oob_fault",  {31'b0, bus.if_fault}, 32'd1);
    chk("oob_instr",  bus.if_instr, 32'h0);
    tick();
    chk("oob_halt",   {31'b0, bus.if_valid}, 32'd0);
    chk("oob_imaddr", bus.im_addr, 32'h7000);

    // Reset mid-stream with 2 buffered entries; reset beats redirect
    bus.id_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3000;
    tick();
    bus.redirect = 1'b0;
    tick();
    tick();
    chk("pre_rst_pc", bus.if_pc, 32'h3000);
    chk("pre_rst_im", bus.im_addr, 32'h3008);
    reset = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h3100;
    tick();
    chk("mid_rst_valid",  {31'b0, bus.if_valid}, 32'd0);
    chk("mid_rst_imaddr", bus.im_addr, 32'h3000);
    reset = 1'b0;
    bus.redirect = 1'b0;
    bus.id_ready = 1'b1;
    tick();
    chk("restart_pc",    bus.if_pc, 32'h3000);
    chk("restart_instr", bus.if_instr, 32'h1000_0000);
    tick();
    chk("restart_pc2",   bus.if_pc, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
